// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage.
//
// Owns the architectural fetch PC, issues one outstanding request at a time
// to instruction memory and hands fetched words (with their PC+1) to decode
// through a 2-entry output/skid buffer. Redirects from the branch unit flush
// the buffer; a request already issued to memory is drained (its data thrown
// away) before fetching resumes at the redirect target.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      decode cannot accept this cycle
//   PC_select, PC_next         redirect request and target
//   imem_req/addr/ack/rdata    instruction memory handshake
//   instr_valid, instr         instruction presented to decode
//   PC_plus_one                address of instr + 1
//   perf_stall_cnt/flush_cnt   performance counters
//
// Optional feature: define FETCH_PERF_CNT_EN to build the saturating
// performance counters; otherwise both counter ports read 0.

module fetch_unit #(
    parameter int                    PC_WIDTH     = 16,
    parameter int                    INSTR_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   PC_select,
    input  logic [PC_WIDTH-1:0]    PC_next,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    PC_plus_one,
    output logic [15:0]            perf_stall_cnt,
    output logic [15:0]            perf_flush_cnt
);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [PC_WIDTH-1:0]    drain_addr;

    logic                   out_valid;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]    out_ppo;
    logic                   skid_valid;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_ppo;

    logic                   ack_fire;
    logic                   consume;
    logic [PC_WIDTH-1:0]    ack_ppo;

    assign ack_fire    = imem_req & imem_ack;
    assign consume     = out_valid & ~stall;
    assign ack_ppo     = imem_addr + 1'b1;

    assign instr_valid = out_valid;
    assign instr       = out_instr;
    assign PC_plus_one = out_ppo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Request is gated by rst_n so it drops the moment reset asserts.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        case (state_q)
            FETCH: begin
                // A full skid means both entries are occupied: no room for
                // another word, so hold off. The skid only fills on an ack,
                // so an outstanding request is never retracted.
                imem_req  = rst_n & ~skid_valid;
                imem_addr = fetch_pc;
                if (PC_select && imem_req && !imem_ack)
                    state_d = DRAIN;
            end
            DRAIN: begin
                // The issued request cannot be aborted; wait for its ack.
                // An ack completes the drain even if another redirect
                // arrives in the same cycle (that redirect only moves
                // fetch_pc, and nothing is outstanding any more).
                imem_req  = rst_n;
                imem_addr = drain_addr;
                if (imem_ack)
                    state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_VECTOR;
            drain_addr <= '0;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_ppo    <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_ppo   <= '0;
        end else if (PC_select) begin
            // Redirect beats stall and ack: flush both entries, drop any
            // returning data, and remember the address still owed by memory.
            fetch_pc   <= PC_next;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            if (state_q == FETCH && imem_req && !imem_ack)
                drain_addr <= imem_addr;
        end else if (state_q == FETCH) begin
            if (ack_fire)
                fetch_pc <= fetch_pc + 1'b1;
            if (consume) begin
                // Skid and ack are mutually exclusive (full skid blocks req).
                if (skid_valid) begin
                    out_instr  <= skid_instr;
                    out_ppo    <= skid_ppo;
                    skid_valid <= 1'b0;
                end else if (ack_fire) begin
                    out_instr  <= imem_rdata;
                    out_ppo    <= ack_ppo;
                end else begin
                    out_valid  <= 1'b0;
                end
            end else if (ack_fire) begin
                if (!out_valid) begin
                    out_valid  <= 1'b1;
                    out_instr  <= imem_rdata;
                    out_ppo    <= ack_ppo;
                end else begin
                    skid_valid <= 1'b1;
                    skid_instr <= imem_rdata;
                    skid_ppo   <= ack_ppo;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        flush_hit;

    // A redirect counts as a flush only if it throws away real work.
    assign flush_hit = PC_select & (out_valid | skid_valid | imem_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && out_valid && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_hit && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_stall_cnt = 16'h0000;
    assign perf_flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// stream checked against an in-order PC stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        pc_select = 1'b0;
    logic [15:0] pc_next = '0;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic        instr_valid;
    logic [15:0] instr, pc_plus_one, perf_stall_cnt, perf_flush_cnt;

    // second instance: reset vector near the top of the address space
    logic        req_w, valid_w;
    logic [15:0] addr_w, instr_w, ppo_w, pstall_w, pflush_w;

    int n_checks = 0;
    int n_fail   = 0;

    int wait_states = 0;
    bit rand_wait   = 1'b0;
    int cur_wait;
    int wcnt;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Memory model: acks after cur_wait idle cycles of a held request.
    assign imem_ack   = imem_req && (wcnt >= cur_wait);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt     <= 0;
            cur_wait <= wait_states;
        end else if (imem_req && imem_ack) begin
            wcnt     <= 0;
            cur_wait <= rand_wait ? int'($urandom_range(0, 3)) : wait_states;
        end else if (imem_req) begin
            wcnt <= wcnt + 1;
        end
    end

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .PC_select(pc_select), .PC_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .PC_plus_one(pc_plus_one),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    fetch_unit #(.RESET_VECTOR(16'hFFFE)) dut_w (
        .clk(clk), .rst_n(rst_n), .stall(1'b0),
        .PC_select(1'b0), .PC_next(16'h0000),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(req_w), .imem_rdata(mem_word(addr_w)),
        .instr_valid(valid_w), .instr(instr_w), .PC_plus_one(ppo_w),
        .perf_stall_cnt(pstall_w), .perf_flush_cnt(pflush_w)
    );

    task automatic do_reset(input int w, input bit r);
        rst_n       = 1'b0;
        stall       = 1'b0;
        pc_select   = 1'b0;
        pc_next     = '0;
        wait_states = w;
        rand_wait   = r;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [15:0] e;
        rst_n = 1'b0; stall = 1'b0; pc_select = 1'b0; wait_states = 0; rand_wait = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0 ||
            pc_plus_one !== 16'h0 || perf_stall_cnt !== 16'h0 || perf_flush_cnt !== 16'h0 ||
            req_w !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h ppo=%h ps=%h pf=%h req_w=%b, required all 0",
                     imem_req, instr_valid, instr, pc_plus_one, perf_stall_cnt, perf_flush_cnt, req_w);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'(c)) begin
                n_fail++;
                $display("FAIL reset_addr c%0d: req=%b addr=%h, required 1/%h", c, imem_req, imem_addr, 16'(c));
            end
            if (c >= 1) begin
                n_checks++;
                if (instr_valid !== 1'b1 || pc_plus_one !== 16'(c) || instr !== mem_word(16'(c - 1))) begin
                    n_fail++;
                    $display("FAIL reset_out c%0d: valid=%b ppo=%h instr=%h, required 1/%h/%h",
                             c, instr_valid, pc_plus_one, instr, 16'(c), mem_word(16'(c - 1)));
                end
            end
            if (c <= 2) begin
                e = 16'hFFFE + 16'(c);
                n_checks++;
                if (addr_w !== e) begin
                    n_fail++;
                    $display("FAIL wrap_addr c%0d: addr=%h, required %h", c, addr_w, e);
                end
            end
            if (c >= 1) begin
                e = 16'hFFFF + 16'(c - 1);
                n_checks++;
                if (ppo_w !== e || valid_w !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_ppo c%0d: ppo=%h valid=%b, required %h/1", c, ppo_w, valid_w, e);
                end
            end
            @(negedge clk);
        end
        // reset in the middle of a live request must drop it at once
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midreq: req=%b, required 0", imem_req);
        end
    endtask

    task automatic test_wait_states;
        logic [15:0] ea;
        do_reset(2, 1'b0);
        for (int c = 0; c < 12; c++) begin
            #1;
            ea = 16'(c / 3);
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== ea || imem_ack !== (c % 3 == 2)) begin
                n_fail++;
                $display("FAIL wait_req c%0d: req=%b addr=%h ack=%b, required 1/%h/%b",
                         c, imem_req, imem_addr, imem_ack, ea, (c % 3 == 2));
            end
            n_checks++;
            if (instr_valid !== (c >= 3 && c % 3 == 0)) begin
                n_fail++;
                $display("FAIL wait_valid c%0d: valid=%b, required %b", c, instr_valid, (c >= 3 && c % 3 == 0));
            end
            if (c >= 3 && c % 3 == 0) begin
                n_checks++;
                if (instr !== mem_word(16'(c / 3 - 1))) begin
                    n_fail++;
                    $display("FAIL wait_instr c%0d: instr=%h, required %h", c, instr, mem_word(16'(c / 3 - 1)));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall;
        logic [15:0] exp_pc = '0;
        do_reset(0, 1'b0);
        for (int c = 0; c < 13; c++) begin
            stall = (c >= 3 && c <= 6);
            #1;
            if (c == 3) begin
                n_checks++;
                if (imem_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_skidfill: req=%b, required 1", imem_req);
                end
            end
            if (c >= 4 && c <= 6) begin
                n_checks++;
                if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== mem_word(16'h2) || pc_plus_one !== 16'h3) begin
                    n_fail++;
                    $display("FAIL stall_hold c%0d: req=%b valid=%b instr=%h ppo=%h, required 0/1/%h/0003",
                             c, imem_req, instr_valid, instr, pc_plus_one, mem_word(16'h2));
                end
            end
            if (instr_valid && !stall) begin
                n_checks++;
                if (instr !== mem_word(exp_pc) || pc_plus_one !== exp_pc + 16'h1) begin
                    n_fail++;
                    $display("FAIL stall_stream c%0d: instr=%h ppo=%h, required %h/%h",
                             c, instr, pc_plus_one, mem_word(exp_pc), exp_pc + 16'h1);
                end
                exp_pc++;
            end
            @(negedge clk);
        end
        stall = 1'b0;
        n_checks++;
        if (exp_pc !== 16'd8) begin
            n_fail++;
            $display("FAIL stall_count: consumed=%0d, required 8", exp_pc);
        end
    endtask

    task automatic test_redirect_drain;
        bit found = 1'b0;
        do_reset(2, 1'b0);
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (imem_req && imem_addr == 16'h0005) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL drain_timeout: request to 0005 not seen within 40 cycles, required seen");
            return;
        end
        pc_select = 1'b1;
        pc_next   = 16'h0040;
        @(negedge clk);
        pc_select = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            if (c <= 2) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0005 || imem_ack !== (c == 2)) begin
                    n_fail++;
                    $display("FAIL drain_hold c%0d: req=%b addr=%h ack=%b, required 1/0005/%b",
                             c, imem_req, imem_addr, imem_ack, (c == 2));
                end
            end
            if (c == 3) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
                    n_fail++;
                    $display("FAIL drain_next: req=%b addr=%h, required 1/0040", imem_req, imem_addr);
                end
            end
            if (c <= 5) begin
                n_checks++;
                if (instr_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL drain_valid c%0d: valid=%b, required 0", c, instr_valid);
                end
            end else begin
                n_checks++;
                if (instr_valid !== 1'b1 || instr !== mem_word(16'h0040) || pc_plus_one !== 16'h0041) begin
                    n_fail++;
                    $display("FAIL drain_first: valid=%b instr=%h ppo=%h, required 1/%h/0041",
                             instr_valid, instr, pc_plus_one, mem_word(16'h0040));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_ack;
        do_reset(0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            pc_select = (c == 3);
            pc_next   = 16'h1234;
            #1;
            if (c == 3) begin
                n_checks++;
                if (imem_ack !== 1'b1) begin
                    n_fail++;
                    $display("FAIL redir_ack_setup: ack=%b, required 1", imem_ack);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h1234 || instr_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL redir_ack_next: req=%b addr=%h valid=%b, required 1/1234/0",
                             imem_req, imem_addr, instr_valid);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (instr_valid !== 1'b1 || instr !== mem_word(16'h1234) || pc_plus_one !== 16'h1235) begin
                    n_fail++;
                    $display("FAIL redir_ack_first: valid=%b instr=%h ppo=%h, required 1/%h/1235",
                             instr_valid, instr, pc_plus_one, mem_word(16'h1234));
                end
            end
            @(negedge clk);
        end
        pc_select = 1'b0;
    endtask

    task automatic test_perf;
        logic [15:0] es, ef;
`ifdef FETCH_PERF_CNT_EN
        es = 16'd3; ef = 16'd1;
`else
        es = 16'd0; ef = 16'd0;
`endif
        do_reset(0, 1'b0);
        for (int c = 0; c < 9; c++) begin
            stall     = (c >= 2 && c <= 4);
            pc_select = (c == 6);
            pc_next   = 16'h0100;
            #1;
            @(negedge clk);
        end
        stall = 1'b0; pc_select = 1'b0;
        #1;
        n_checks++;
        if (perf_stall_cnt !== es || perf_flush_cnt !== ef) begin
            n_fail++;
            $display("FAIL perf_cnt: stall_cnt=%0d flush_cnt=%0d, required %0d/%0d",
                     perf_stall_cnt, perf_flush_cnt, es, ef);
        end
    endtask

    // Randomized stall/redirect/wait-state run: decode must see the
    // instructions at consecutive PCs from the last redirect target (or reset
    // vector), with no loss, duplication or stale data, and must see a held
    // output while stalled.
    task automatic test_random;
        logic [15:0] exp_pc = '0;
        logic [15:0] prev_instr = '0, prev_ppo = '0;
        bit prev_hold = 1'b0;
        int consumed = 0;
        do_reset(0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            stall     = ($urandom_range(0, 3) == 0);
            pc_select = ($urandom_range(0, 19) == 0);
            pc_next   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                                    : 16'($urandom);
            #1;
            if (prev_hold) begin
                n_checks++;
                if (instr_valid !== 1'b1 || instr !== prev_instr || pc_plus_one !== prev_ppo) begin
                    n_fail++;
                    $display("FAIL rand_hold c%0d: valid=%b instr=%h ppo=%h, required 1/%h/%h",
                             c, instr_valid, instr, pc_plus_one, prev_instr, prev_ppo);
                end
            end
            if (instr_valid && !stall) begin
                n_checks++;
                if (instr !== mem_word(exp_pc) || pc_plus_one !== exp_pc + 16'h1) begin
                    n_fail++;
                    $display("FAIL rand_stream c%0d: instr=%h ppo=%h, required %h/%h",
                             c, instr, pc_plus_one, mem_word(exp_pc), exp_pc + 16'h1);
                end
                exp_pc++;
                consumed++;
            end
            prev_hold  = instr_valid && stall && !pc_select;
            prev_instr = instr;
            prev_ppo   = pc_plus_one;
            if (pc_select) exp_pc = pc_next;
            @(negedge clk);
        end
        stall = 1'b0; pc_select = 1'b0;
        n_checks++;
        if (consumed < 50) begin
            n_fail++;
            $display("FAIL rand_progress: consumed=%0d, required >= 50", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_stall();
        test_redirect_drain();
        test_redirect_ack();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the branch unit's consumer path.
- Owns the architectural fetch PC and issues requests to instruction memory.
- Presents fetched instructions and their PC_plus_one to decode through a 2-entry output/skid buffer.
- Applies redirects from the branch unit (PC_select/PC_next), flushing wrong-path instructions, including any in-flight memory request.

Parameters:
PC_WIDTH, 16, width of PC and instruction-memory address
INSTR_WIDTH, 16, instruction word width
RESET_VECTOR, 16'h0000, fetch PC after reset

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  decode cannot accept; hold instr/instr_valid/PC_plus_one
PC_select  input  1  redirect request from branch unit
PC_next  input  PC_WIDTH  redirect target
imem_req  output  1  memory request valid
imem_addr  output  PC_WIDTH  request address
imem_ack  input  1  request completes at this edge; imem_rdata valid
imem_rdata  input  INSTR_WIDTH  fetched word
instr_valid  output  1  instr holds a valid instruction
instr  output  INSTR_WIDTH  instruction to decode
PC_plus_one  output  PC_WIDTH  address of instr + 1, to branch unit
perf_stall_cnt  output  16  see Optional Feature
perf_flush_cnt  output  16  see Optional Feature

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_VECTOR, state=FETCH, both buffer entries empty, instr_valid=0, instr=0, PC_plus_one=0, perf counters=0. imem_req=0 while in reset.
- States: FETCH, DRAIN.
- FETCH:
  - imem_req=1 iff skid entry empty; imem_addr=fetch_pc.
  - Request stays high with a stable address until acked; stall never retracts it.
- Consume: an instruction is consumed at an edge where instr_valid=1 and stall=0.
- Ack in FETCH with no redirect:
  - fetch_pc <= fetch_pc+1, wrapping 0xFFFF->0x0000.
  - Data goes to the output register if it is empty or being consumed this edge. Otherwise it goes to the skid entry.
  - PC_plus_one is captured as addr+1, mod 2^PC_WIDTH.
- Skid: when the output register is consumed and skid is full, skid moves to output at the same edge.
- Throughput: zero-wait memory (ack in the same cycle as req) gives 1 instr/cycle.
- Latency: instr_valid rises the edge after ack.
- First request is the first cycle after rst_n deasserts.
- Redirect (PC_select=1) has priority over stall and ack:
  - fetch_pc <= PC_next.
  - Output register and skid are cleared (instr_valid=0 next cycle).
  - Any ack data in the same cycle is discarded.
  - If imem_req=1 and imem_ack=0 that cycle, go to DRAIN and latch drain_addr=current imem_addr. Otherwise stay in FETCH, and the request at PC_next issues next cycle.
- DRAIN:
  - imem_req=1, imem_addr=drain_addr, since an issued request cannot be aborted.
  - On ack, discard the data and go to FETCH.
  - Redirect in DRAIN: fetch_pc <= PC_next, stay in DRAIN.
  - instr_valid stays 0.
- stall with instr_valid=0 has no effect.
- Reset asserted mid-request drops imem_req immediately. Memory must tolerate an abandoned request on reset.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - perf_stall_cnt increments each cycle with stall=1 and instr_valid=1.
  - perf_flush_cnt increments on each redirect that discards at least one valid buffer entry or an in-flight/acking request.
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter registers exist.

Test Plan:
- Reset release, zero-wait memory, stall=0 -> imem_addr 0,1,2,3 on consecutive cycles; instr_valid=1 from cycle 2; PC_plus_one 1,2,3.
- Memory with 2 wait states -> imem_req held high with addr stable for 3 cycles per word; one instr_valid pulse per ack.
- stall=1 held 4 cycles with zero-wait memory -> one extra word enters skid, then imem_req=0. instr/PC_plus_one frozen. On release, output sequence continues with no loss or duplicate.
- Redirect PC_select=1, PC_next=0x0040 while a request to 0x0005 is waiting (wait-state memory) -> DRAIN keeps addr 0x0005 until ack, data discarded, next request 0x0040, instr_valid=0 throughout.
- Redirect coincident with ack -> ack data dropped, next cycle imem_addr=PC_next, no stale instruction reaches decode.
- RESET_VECTOR=16'hFFFE -> fetch addresses FFFE, FFFF, 0000; PC_plus_one FFFF, 0000, 0001.
- With FETCH_PERF_CNT_EN: 3 stalled cycles plus 1 flushing redirect -> perf_stall_cnt=3, perf_flush_cnt=1.
